ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction fetch sequencer for the MIPS core; owns the PC and drives the address port of the combinational instruction memory (inst_mem).
- Buffers fetched words in a small FIFO and hands them to decode through a valid/ready handshake.
- Supports halt, branch/jump redirect with flush, and an out-of-range fetch fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 128, size of instruction memory in bytes; legal fetch addresses are 0..MEM_BYTES-4.
- DEPTH, 2, fetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to inst_mem; equals pc.
- imem_inst  in  32  instruction word from inst_mem, combinational from imem_addr.
- halt  in  1  level; while high, no new fetches.
- redirect_valid  in  1  one-cycle branch/jump request.
- redirect_target  in  32  new PC for the redirect.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  address of head instruction.
- align_err  out  1  one-cycle pulse: redirect_target[1:0] != 0.
- fetch_fault  out  1  sticky: pc reached an address >= MEM_BYTES.
- fetch_count  out  16  number of words pushed since reset; wraps modulo 2^16.

Behaviour:
- Reset (synchronous, clk edge with reset=1): pc=RESET_PC, FIFO emptied, out_valid=0, out_inst=0, out_pc=0, align_err=0, fetch_fault=0, fetch_count=0. Reset overrides every other input, including mid-redirect and mid-handshake.
- imem_addr = pc at all times. The instruction is sampled the same cycle, so fetch latency is 1 cycle from pc to FIFO entry.
- pop = out_valid & out_ready.
- push = !halt & !redirect_valid & !fetch_fault & (count < DEPTH | pop). Full-FIFO push is allowed only when a pop happens in the same cycle.
- On push:
  - write {pc, imem_inst} at the tail.
  - pc <= pc + 4.
  - fetch_count <= fetch_count + 1.
- Simultaneous push and pop: count unchanged, entries stay in order.
- out_valid = (count != 0). out_inst and out_pc are the head entry, registered. When the FIFO is empty they hold their last values (0 after reset).
- Redirect (redirect_valid=1), highest priority after reset:
  - FIFO flushed: count=0 next cycle, any same-cycle pop is discarded and decode must not treat it as accepted.
  - pc <= {redirect_target[31:2], 2'b00}.
  - fetch_fault cleared.
  - no push that cycle.
  - align_err=1 on the next cycle if redirect_target[1:0] != 0, otherwise 0.
- Fault: on any edge where no redirect occurs and the next pc is >= MEM_BYTES, fetch_fault <= 1.
  - While fetch_fault=1, pushes stop and pc holds.
  - The FIFO still drains normally.
  - Cleared only by redirect or reset.
- Halt: pushes stop and pc holds; draining continues. Redirect during halt is still taken.
- halt asserted together with redirect: the redirect is applied, then no fetch while halt stays high.
- Steady state with out_ready=1, no halt: one instruction per cycle; first out_valid appears 1 cycle after reset deasserts.
- pc is 32-bit and wraps naturally. The fault check is compared against MEM_BYTES, not wrap.

Test Plan:
- Reset then release, out_ready=1, inst_mem loaded with words at 0..32: out_pc sequence 0,4,8,12,... one per cycle from cycle 1. out_inst matches the memory contents. fetch_count increments by 1 per cycle.
- out_ready=0 after reset, DEPTH=2: out_valid=1 with out_pc=0. The FIFO fills with pc 0 and 4, then pc holds at 8. After out_ready=1 the bench sees 0,4,8 in order with no loss or duplicates.
- At a steady stream, pulse redirect_valid with target 0x18: FIFO flushed, the next out_valid entry has out_pc=0x18, then 0x1C. align_err stays 0.
- Redirect with target 0x0E: pc becomes 0x0C, align_err pulses 1 for exactly one cycle, and the first new entry has out_pc=0x0C.
- MEM_BYTES=32, free-run: entries with pc 0..28 are delivered, then fetch_fault=1 and no further pushes. A redirect to 0 clears fetch_fault and restarts at pc 0.
- Hold halt=1 for 3 cycles mid-stream: pc and fetch_count are frozen, and the FIFO drains to out_valid=0. Assert reset during a full FIFO: next cycle out_valid=0, pc=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Bundle between the fetch sequencer, the instruction memory and decode.
// Decode handshake: an entry moves when out_valid && out_ready at a rising clk edge.
// out_valid never depends on out_ready, and a redirect in the same cycle cancels that move.
interface ifetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        align_err;
  logic        fetch_fault;
  logic [15:0] fetch_count;
  logic        fetch_state;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  halt,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output align_err,
    output fetch_fault,
    output fetch_count,
    output fetch_state
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output halt,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  align_err,
    input  fetch_fault,
    input  fetch_count,
    input  fetch_state
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads inst_mem combinationally and
// queues {pc, inst} pairs in a small FIFO for decode. Handles halt, redirect and fault.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter int          DEPTH     = 2
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_ctrl_if.master bus
);

  localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } fetch_state_t;

  fetch_state_t  state;
  fetch_state_t  state_next;

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;
  logic          align_q;
  logic [15:0]   fetch_cnt;

  logic          fault_hold;
  logic          pop;
  logic          push;
  logic          fifo_nonempty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a redirect always leaves the fault; otherwise the fault is sticky.
  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = S_RUN;
    end else if (pc_next >= MEM_LIMIT) begin
      state_next = S_FAULT;
    end
  end

  // Outputs of the FSM and handshake qualifiers
  always_comb begin
    fault_hold    = (state == S_FAULT);
    fifo_nonempty = (count != '0);
    pop           = fifo_nonempty && bus.out_ready;
    push          = !bus.halt && !bus.redirect_valid && !fault_hold &&
                    ((count < CW'(DEPTH)) || pop);
  end

  always_comb begin
    pc_next = pc;
    if (bus.redirect_valid) begin
      pc_next = {bus.redirect_target[31:2], 2'b00};
    end else if (push) begin
      pc_next = pc + 32'd4;
    end
  end

  assign count_after_pop = count - CW'(pop);
  assign rd_ptr_inc      = rd_ptr + PW'(1);

  // FIFO storage carries no reset; the occupancy count decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= bus.imem_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_pc   <= '0;
      head_inst <= '0;
      align_q   <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      pc      <= pc_next;
      align_q <= bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr    <= wr_ptr + PW'(1);
          fetch_cnt <= fetch_cnt + 16'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr_inc;
        end
        count <= count_after_pop + CW'(push);
        // Head registers track the oldest live entry; on empty they keep the last value.
        if (count_after_pop != '0) begin
          head_pc   <= pop ? fifo_pc[rd_ptr_inc]   : fifo_pc[rd_ptr];
          head_inst <= pop ? fifo_inst[rd_ptr_inc] : fifo_inst[rd_ptr];
        end else if (push) begin
          head_pc   <= pc;
          head_inst <= bus.imem_inst;
        end
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.out_valid   = fifo_nonempty;
  assign bus.out_pc      = head_pc;
  assign bus.out_inst    = head_inst;
  assign bus.align_err   = align_q;
  assign bus.fetch_fault = fault_hold;
  assign bus.fetch_count = fetch_cnt;
  assign bus.fetch_state = state;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a table of per-cycle vectors with hand-computed
// expectations, then a free-run-to-fault sequence scored against an expected queue.
module tb_ifetch_ctrl;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (32),
    .DEPTH     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory model: 8 words, out-of-range reads return a marker
  function automatic logic [31:0] fi(input logic [31:0] a);
    return 32'h3C00_0007 | (a << 4);
  endfunction

  logic [31:0] mem_words [8];
  initial begin
    for (int i = 0; i < 8; i++) mem_words[i] = fi(32'(i * 4));
  end
  assign bus.imem_inst = (bus.imem_addr < 32'd32) ? mem_words[bus.imem_addr[4:2]] : 32'hBAD0_BAD0;

  typedef struct {
    logic        rst;
    logic        halt;
    logic        rv;
    logic [31:0] rt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eaddr;
    logic        ea;
    logic        ef;
    logic [15:0] ecnt;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] exp_q[$];

  function automatic vec_t mk(input logic rst, input logic halt, input logic rv,
                              input logic [31:0] rt, input logic rdy, input logic ev,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic [31:0] eaddr, input logic ea, input logic ef,
                              input logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.halt = halt; v.rv = rv; v.rt = rt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einst = einst; v.eaddr = eaddr;
    v.ea = ea; v.ef = ef; v.ecnt = ecnt;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got=%h expected=%h", name, got, exp);
  endtask

  // Driver: apply inputs, step one edge, settle past the edge
  task automatic drive(input logic rst, input logic halt, input logic rv,
                       input logic [31:0] rt, input logic rdy);
    reset               = rst;
    bus.halt            = halt;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.out_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(v.ev));
    chk($sformatf("v%0d_out_pc", i), bus.out_pc, v.epc);
    chk($sformatf("v%0d_out_inst", i), bus.out_inst, v.einst);
    chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, v.eaddr);
    chk($sformatf("v%0d_align_err", i), 32'(bus.align_err), 32'(v.ea));
    chk($sformatf("v%0d_fetch_fault", i), 32'(bus.fetch_fault), 32'(v.ef));
    chk($sformatf("v%0d_fetch_count", i), 32'(bus.fetch_count), 32'(v.ecnt));
  endtask

  initial begin
    bit done;
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.out_ready = 1'b0;

    //            rst halt rv  rt      rdy | ev  epc     einst       eaddr   ea ef cnt
    vt.push_back(mk(1, 0, 0, 32'h00, 1,    0, 32'h00, 32'h0,       32'h00, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h00, fi(32'h00),  32'h04, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h04, fi(32'h04),  32'h08, 0, 0, 2));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h08, fi(32'h08),  32'h0C, 0, 0, 3));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h0C, fi(32'h0C),  32'h10, 0, 0, 4));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h0C, fi(32'h0C),  32'h14, 0, 0, 5));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h0C, fi(32'h0C),  32'h14, 0, 0, 5));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h0C, fi(32'h0C),  32'h14, 0, 0, 5));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h10, fi(32'h10),  32'h18, 0, 0, 6));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h14, fi(32'h14),  32'h1C, 0, 0, 7));
    vt.push_back(mk(0, 0, 1, 32'h18, 1,    0, 32'h14, fi(32'h14),  32'h18, 0, 0, 7));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h18, fi(32'h18),  32'h1C, 0, 0, 8));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h1C, fi(32'h1C),  32'h20, 0, 1, 9));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    0, 32'h1C, fi(32'h1C),  32'h20, 0, 1, 9));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    0, 32'h1C, fi(32'h1C),  32'h20, 0, 1, 9));
    vt.push_back(mk(0, 0, 1, 32'h0E, 1,    0, 32'h1C, fi(32'h1C),  32'h0C, 1, 0, 9));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h0C, fi(32'h0C),  32'h10, 0, 0, 10));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h10, fi(32'h10),  32'h14, 0, 0, 11));
    vt.push_back(mk(0, 1, 0, 32'h00, 1,    0, 32'h10, fi(32'h10),  32'h14, 0, 0, 11));
    vt.push_back(mk(0, 1, 0, 32'h00, 1,    0, 32'h10, fi(32'h10),  32'h14, 0, 0, 11));
    vt.push_back(mk(0, 1, 0, 32'h00, 1,    0, 32'h10, fi(32'h10),  32'h14, 0, 0, 11));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h14, fi(32'h14),  32'h18, 0, 0, 12));
    vt.push_back(mk(0, 1, 1, 32'h04, 1,    0, 32'h14, fi(32'h14),  32'h04, 0, 0, 12));
    vt.push_back(mk(0, 1, 0, 32'h00, 1,    0, 32'h14, fi(32'h14),  32'h04, 0, 0, 12));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h04, fi(32'h04),  32'h08, 0, 0, 13));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h04, fi(32'h04),  32'h0C, 0, 0, 14));
    vt.push_back(mk(0, 0, 0, 32'h00, 0,    1, 32'h04, fi(32'h04),  32'h0C, 0, 0, 14));
    vt.push_back(mk(1, 0, 1, 32'h10, 1,    0, 32'h00, 32'h0,       32'h00, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h00, 1,    1, 32'h00, fi(32'h00),  32'h04, 0, 0, 1));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].halt, vt[i].rv, vt[i].rt, vt[i].rdy);
      check_vec(i, vt[i]);
    end

    // Free-run from reset into the fault, then recover with a redirect to 0
    drive(1, 0, 0, 32'h0, 1);
    for (int a = 0; a < 32; a += 4) exp_q.push_back(32'(a));
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      drive(0, 0, 0, 32'h0, 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("fault_extra_entry", bus.out_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("fault_run_pc", bus.out_pc, e);
          chk("fault_run_inst", bus.out_inst, fi(e));
        end
      end
      if (bus.fetch_fault && !bus.out_valid) done = 1'b1;
    end
    chk("fault_reached", 32'(done), 32'd1);
    chk("fault_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("fault_count", 32'(bus.fetch_count), 32'd8);
    chk("fault_pc_hold", bus.imem_addr, 32'h20);
    drive(0, 0, 0, 32'h0, 1);
    chk("fault_sticky", 32'(bus.fetch_fault), 32'd1);
    chk("fault_no_push", 32'(bus.fetch_count), 32'd8);

    drive(0, 0, 1, 32'h0, 1);
    chk("recover_fault_clr", 32'(bus.fetch_fault), 32'd0);
    chk("recover_pc", bus.imem_addr, 32'h0);
    chk("recover_empty", 32'(bus.out_valid), 32'd0);
    drive(0, 0, 0, 32'h0, 1);
    chk("recover_valid", 32'(bus.out_valid), 32'd1);
    chk("recover_out_pc", bus.out_pc, 32'h0);
    chk("recover_out_inst", bus.out_inst, fi(32'h0));
    chk("recover_count", 32'(bus.fetch_count), 32'd9);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
